// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-visible 16-bit control register bank.
// Takes the decoder's command/data stream, performs writes, counts rejected
// writes, and serves register readback as a low-byte/high-byte sequence.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [15:0] ID_VALUE = 16'hA5C3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_ss,
    input  logic [7:0]               address,
    input  logic                     address_valid,
    input  logic [15:0]              data,
    input  logic                     data_valid,
    input  logic                     tx_ack,
    output logic [7:0]               tx_data,
    output logic                     wr_strobe,
    output logic [6:0]               wr_index,
    output logic [7:0]               err_count,
    output logic [16*NUM_REGS-1:0]   regs_flat
);

    typedef enum logic [1:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_END
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shadow_q, shadow_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_rd_q, cmd_rd_d;
    logic [6:0]  cmd_idx_q, cmd_idx_d;

    logic [15:0] regs_q [NUM_REGS-1:2];
    logic [15:0] regs_d [NUM_REGS-1:2];

    logic        wr_strobe_q, wr_strobe_d;
    logic [6:0]  wr_index_q, wr_index_d;
    logic [7:0]  err_count_q, err_count_d;

    logic [15:0] rd_value;
    logic        wr_hit;

    // Readback value for the index carried by the incoming command byte.
    always_comb begin
        rd_value = 16'hDEAD;
        if (address[6:0] == 7'd0) begin
            rd_value = ID_VALUE;
        end else if (address[6:0] == 7'd1) begin
            rd_value = {8'h00, err_count_q};
        end else begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (address[6:0] == 7'(i)) begin
                    rd_value = regs_q[i];
                end
            end
        end
    end

    // Command latch: data_valid closes the old command before a coincident
    // address_valid opens the new one.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_idx_d   = cmd_idx_q;
        if (data_valid) begin
            cmd_valid_d = 1'b0;
        end
        if (address_valid) begin
            cmd_valid_d = 1'b1;
            cmd_rd_d    = address[7];
            cmd_idx_d   = address[6:0];
        end
    end

    // Write execution against the latched command; rejected writes bump the
    // saturating error counter, a status write with bit 0 set clears it.
    always_comb begin
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        err_count_d = err_count_q;
        wr_hit      = 1'b0;
        if (data_valid && cmd_valid_q && !cmd_rd_q) begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (cmd_idx_q == 7'(i)) begin
                    regs_d[i] = data;
                    wr_hit    = 1'b1;
                end
            end
            if (wr_hit) begin
                wr_strobe_d = 1'b1;
                wr_index_d  = cmd_idx_q;
            end else if (cmd_idx_q == 7'd1 && data[0]) begin
                err_count_d = '0;
                wr_strobe_d = 1'b1;
                wr_index_d  = cmd_idx_q;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Readback FSM next state and byte presented to the SPI transmitter.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (address_valid && address[7]) begin
                    shadow_d = rd_value;
                    state_d  = RD_LO;
                end
            end
            RD_LO: begin
                tx_data = shadow_q[7:0];
                if (tx_ack) state_d = RD_HI;
            end
            RD_HI: begin
                tx_data = shadow_q[15:8];
                if (tx_ack) state_d = RD_END;
            end
            default: begin
                tx_data = 8'h00;
            end
        endcase
        if (spi_ss) begin
            state_d = IDLE;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_idx_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            err_count_q <= '0;
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_idx_q   <= cmd_idx_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            err_count_q <= err_count_d;
            regs_q      <= regs_d;
        end
    end

    // Export register contents, with the constant and status entries filled in.
    always_comb begin
        regs_flat        = '0;
        regs_flat[15:0]  = ID_VALUE;
        regs_flat[31:16] = {8'h00, err_count_q};
        for (int unsigned i = 2; i < NUM_REGS; i++) begin
            regs_flat[16*i +: 16] = regs_q[i];
        end
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign err_count = err_count_q;

endmodule
